bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
It is the inverse of the BCD-digit accumulator: it takes the stored 10-bit binary total and produces decimal digits for the 7-segment display path.
A start/busy/done handshake means the display controller only samples digits on done.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bin_to_bcd_seq_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADJ_THRESH  = 5;

    function automatic int bcd_vec_w(input int ndig);
        return ndig * BCD_DIGIT_W;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and digit bus
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int BIN_W = 10
);
    logic                   start;
    logic [BIN_W-1:0]       bin_in;
    logic                   busy;
    logic                   done;
    logic [BCD_DIGIT_W-1:0] millares;
    logic [BCD_DIGIT_W-1:0] centenas;
    logic [BCD_DIGIT_W-1:0] decenas;
    logic [BCD_DIGIT_W-1:0] unidades;
    logic                   range_err;

    modport master (
        output start, bin_in,
        input  busy, done, millares, centenas, decenas, unidades, range_err
    );

    modport slave (
        input  start, bin_in,
        output busy, done, millares, centenas, decenas, unidades, range_err
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);
    // A digit of at most 9 stays within 4 bits after +3, so no carry out exists.
    assign digit_o = (digit_i >= BCD_DIGIT_W'(ADJ_THRESH)) ? digit_i + BCD_DIGIT_W'(3)
                                                          : digit_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential one-bit-per-clock binary-to-BCD converter
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 10,
    parameter int NDIG     = 4,
    parameter int DISP_MAX = 999
) (
    input  logic             clk,
    input  logic             n_reset,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int BCD_W = bcd_vec_w(NDIG);
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_pend_q, err_pend_d;
    logic               range_err_q, range_err_d;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   unused_adj_msb;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Adjusted scratch and remaining binary bits move left together as one register.
    assign shifted        = {adj[BCD_W-2:0], shreg_q, 1'b0};
    assign unused_adj_msb = adj[BCD_W-1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            scratch_q   <= '0;
            digits_q    <= '0;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        err_pend_d  = err_pend_q;
        range_err_d = range_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d    = bus.bin_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    err_pend_d = (32'(bus.bin_in) > 32'(DISP_MAX));
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[BCD_W+BIN_W-1 -: BCD_W];
                shreg_d   = shifted[BIN_W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    digits_d    = shifted[BCD_W+BIN_W-1 -: BCD_W];
                    range_err_d = err_pend_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = (state_q == DONE);
    assign bus.unidades  = digits_q[0*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.decenas   = digits_q[1*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.centenas  = digits_q[2*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.millares  = digits_q[3*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] digits;
        logic        err;
    } vec_t;

    logic clk;
    logic n_reset;
    int   checks;
    int   errors;
    vec_t sb_q[$];
    vec_t tbl[11];

    bin_to_bcd_seq_if #(.BIN_W(10)) bus ();

    bin_to_bcd_seq #(.BIN_W(10), .NDIG(4), .DISP_MAX(999)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dig();
        return {bus.millares, bus.centenas, bus.decenas, bus.unidades};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (n_reset) begin
            if (bus.busy && bus.done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=1 done=1 at %0t", $time);
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(dig()), 32'hFFFF_FFFF);
                end else begin
                    vec_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("digits_%0d", e.bin), 32'(dig()), 32'(e.digits));
                    chk($sformatf("range_err_%0d", e.bin), 32'(bus.range_err), 32'(e.err));
                end
            end
        end
    end

    task automatic push(input logic [9:0] b, input logic [15:0] d, input logic e);
        vec_t v;
        v.bin = b; v.digits = d; v.err = e;
        sb_q.push_back(v);
    endtask

    task automatic start_conv(input logic [9:0] b);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.bin_in = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = n;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int bc;
        checks = 0;
        errors = 0;
        tbl[0]  = '{10'd0,    16'h0000, 1'b0};
        tbl[1]  = '{10'd1,    16'h0001, 1'b0};
        tbl[2]  = '{10'd9,    16'h0009, 1'b0};
        tbl[3]  = '{10'd10,   16'h0010, 1'b0};
        tbl[4]  = '{10'd99,   16'h0099, 1'b0};
        tbl[5]  = '{10'd100,  16'h0100, 1'b0};
        tbl[6]  = '{10'd255,  16'h0255, 1'b0};
        tbl[7]  = '{10'd998,  16'h0998, 1'b0};
        tbl[8]  = '{10'd999,  16'h0999, 1'b0};
        tbl[9]  = '{10'd1023, 16'h1023, 1'b1};
        tbl[10] = '{10'd1000, 16'h1000, 1'b1};

        n_reset    = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #3;
        chk("reset_digits", 32'(dig()), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_range_err", 32'(bus.range_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            push(tbl[i].bin, tbl[i].digits, tbl[i].err);
            start_conv(tbl[i].bin);
            wait_done(lat, bc);
            if (i == 0) begin
                chk("latency", 32'(lat), 32'd11);
                chk("busy_cycles", 32'(bc), 32'd10);
            end
        end

        // Reset in the middle of a conversion: outputs clear at once, no done.
        start_conv(10'd600);
        repeat (5) @(negedge clk);
        chk("mid_busy_before_reset", 32'(bus.busy), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_reset_digits", 32'(dig()), 32'h0);
        chk("mid_reset_range_err", 32'(bus.range_err), 32'd0);
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        push(10'd600, 16'h0600, 1'b0);
        start_conv(10'd600);
        wait_done(lat, bc);

        // Digits hold the previous result during a conversion.
        push(10'd1023, 16'h1023, 1'b1);
        start_conv(10'd1023);
        wait_done(lat, bc);
        push(10'd255, 16'h0255, 1'b0);
        start_conv(10'd255);
        repeat (5) @(negedge clk);
        chk("hold_digits", 32'(dig()), 32'h1023);
        chk("hold_range_err", 32'(bus.range_err), 32'd1);
        wait_done(lat, bc);

        // A start during SHIFT is ignored, not queued.
        push(10'd437, 16'h0437, 1'b0);
        start_conv(10'd437);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.bin_in = 10'd12;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        wait_done(lat, bc);
        repeat (20) @(negedge clk);
        chk("ignored_start_idle", 32'(bus.busy), 32'd0);
        chk("ignored_start_digits", 32'(dig()), 32'h0437);

        // start held high: back-to-back conversions every 12 cycles.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.bin_in = 10'd5;
        push(10'd5, 16'h0005, 1'b0);
        wait_done(lat, bc);
        bus.bin_in = 10'd50;
        push(10'd50, 16'h0050, 1'b0);
        wait_done(lat, bc);
        chk("period_1", 32'(lat), 32'd12);
        bus.bin_in = 10'd500;
        push(10'd500, 16'h0500, 1'b0);
        wait_done(lat, bc);
        chk("period_2", 32'(lat), 32'd12);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
